// File: rtl/sram_port_arbiter_pkg.sv
// Shared types for the SRAM port arbiter: FSM states and the read-pipeline entry.
// ID_WIDTH is sized for the largest supported requester count (4).
package sram_port_arbiter_pkg;

  localparam int NREQ_MAX = 4;
  localparam int ID_WIDTH = $clog2(NREQ_MAX);

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  typedef struct packed {
    logic                vld;
    logic [ID_WIDTH-1:0] id;
  } rd_entry_t;

endpackage

// File: rtl/sram_rr_arbiter.sv
// Round-robin grant among NREQ requesters, scanning upward from the last winner.
// The pointer only moves on a transfer.
module sram_rr_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic                clk0,
  input  logic                rst0,
  input  logic [NREQ-1:0]     valid,
  input  logic                enable,
  input  logic                advance,
  output logic [NREQ-1:0]     grant,
  output logic [ID_WIDTH-1:0] grant_idx
);

  logic [ID_WIDTH-1:0] ptr;
  logic                found;

  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0)         ptr <= ID_WIDTH'(NREQ - 1);
    else if (advance) ptr <= grant_idx;
  end

  // Two passes: indices above the pointer first, then wrap to those at or below it.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (enable && !found && valid[k] && (k > int'(ptr))) begin
        found     = 1'b1;
        grant[k]  = 1'b1;
        grant_idx = ID_WIDTH'(k);
      end
    end
    for (int k = 0; k < NREQ; k++) begin
      if (enable && !found && valid[k] && (k <= int'(ptr))) begin
        found     = 1'b1;
        grant[k]  = 1'b1;
        grant_idx = ID_WIDTH'(k);
      end
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-port OpenRAM macro between NREQ requesters with an optional
// zero-fill after reset. Read data returns two edges after acceptance.
//
// state  | meaning
// S_INIT | writing zero to every word, requesters held off
// S_RUN  | round-robin arbitration, one macro command per cycle
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 2,
  parameter int ADDR_WIDTH = 4,
  parameter int NREQ       = 2,
  parameter bit INIT_ZERO  = 1'b1
) (
  input  logic                       clk0,
  input  logic                       rst0,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ-1:0]            req_we,
  input  logic [NREQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NREQ*DATA_WIDTH-1:0] req_din,
  output logic [NREQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]      rsp_data,
  output logic                       init_done,
  output logic                       csb0,
  output logic                       web0,
  output logic [ADDR_WIDTH-1:0]      addr0,
  output logic [DATA_WIDTH-1:0]      din0,
  input  logic [DATA_WIDTH-1:0]      dout0
);

  localparam state_e RST_STATE = INIT_ZERO ? S_INIT : S_RUN;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] init_cnt, cnt_d;
  logic                  init_done_d;
  logic                  csb_d, web_d;
  logic [ADDR_WIDTH-1:0] addr_d, sel_addr;
  logic [DATA_WIDTH-1:0] din_d, sel_din;
  logic                  sel_we;
  logic [NREQ-1:0]       grant;
  logic [ID_WIDTH-1:0]   grant_idx;
  logic                  arb_en, xfer;
  rd_entry_t             pipe_in;
  rd_entry_t             rd_pipe [2];
  logic [NREQ-1:0]       rsp_onehot;

  // Gated by rst0 so an INIT_ZERO=0 instance shows no ready while held in reset.
  assign arb_en    = (state_q == S_RUN) && !rst0;
  assign xfer      = |grant;
  assign req_ready = grant;

  sram_rr_arbiter #(.NREQ(NREQ)) u_rr (
    .clk0      (clk0),
    .rst0      (rst0),
    .valid     (req_valid),
    .enable    (arb_en),
    .advance   (xfer),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_comb begin
    sel_we   = 1'b0;
    sel_addr = '0;
    sel_din  = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant[k]) begin
        sel_we   = req_we[k];
        sel_addr = req_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
        sel_din  = req_din[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = init_cnt;
    init_done_d = init_done;
    csb_d       = 1'b1;
    web_d       = 1'b1;
    addr_d      = addr0;
    din_d       = din0;
    pipe_in     = '0;
    case (state_q)
      S_INIT: begin
        csb_d  = 1'b0;
        web_d  = 1'b0;
        din_d  = '0;
        addr_d = init_cnt;
        if (init_cnt == {ADDR_WIDTH{1'b1}}) begin
          state_d     = S_RUN;
          init_done_d = 1'b1;
        end else begin
          cnt_d = init_cnt + 1'b1;
        end
      end
      S_RUN: begin
        init_done_d = 1'b1;
        if (xfer) begin
          csb_d       = 1'b0;
          web_d       = ~sel_we;
          addr_d      = sel_addr;
          din_d       = sel_din;
          pipe_in.vld = ~sel_we;
          pipe_in.id  = grant_idx;
        end
      end
      default: state_d = RST_STATE;
    endcase
  end

  always_comb begin
    rsp_onehot = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (rd_pipe[1].vld && (rd_pipe[1].id == ID_WIDTH'(k))) rsp_onehot[k] = 1'b1;
    end
  end

  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      state_q    <= RST_STATE;
      init_cnt   <= '0;
      init_done  <= 1'b0;
      csb0       <= 1'b1;
      web0       <= 1'b1;
      addr0      <= '0;
      din0       <= '0;
      rd_pipe[0] <= '0;
      rd_pipe[1] <= '0;
      rsp_valid  <= '0;
      rsp_data   <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt   <= cnt_d;
      init_done  <= init_done_d;
      csb0       <= csb_d;
      web0       <= web_d;
      addr0      <= addr_d;
      din0       <= din_d;
      rd_pipe[0] <= pipe_in;
      rd_pipe[1] <= rd_pipe[0];
      rsp_valid  <= rsp_onehot;
      if (rd_pipe[1].vld) rsp_data <= dout0;
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a behavioural OpenRAM-style macro,
// plus a second instance built without zero-fill.
module tb_sram_port_arbiter;

  logic       clk0 = 1'b0;
  logic       rst0 = 1'b1;
  logic [1:0] req_valid = '0, req_we = '0, req_ready, rsp_valid;
  logic [7:0] req_addr = '0;
  logic [3:0] req_din = '0;
  logic [1:0] rsp_data, din0, dout0;
  logic       init_done, csb0, web0;
  logic [3:0] addr0;

  logic [1:0] nz_req_valid = '0, nz_req_ready, nz_rsp_valid, nz_rsp_data, nz_din0;
  logic       nz_init_done, nz_csb0, nz_web0;
  logic [3:0] nz_addr0;
  logic [1:0] nz_dout0 = 2'b00;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk0 = ~clk0;

  sram_port_arbiter #(.DATA_WIDTH(2), .ADDR_WIDTH(4), .NREQ(2), .INIT_ZERO(1'b1)) u_dut (
    .clk0(clk0), .rst0(rst0), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_din(req_din), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .init_done(init_done), .csb0(csb0), .web0(web0), .addr0(addr0), .din0(din0), .dout0(dout0));

  sram_port_arbiter #(.DATA_WIDTH(2), .ADDR_WIDTH(4), .NREQ(2), .INIT_ZERO(1'b0)) u_dut_nz (
    .clk0(clk0), .rst0(rst0), .req_valid(nz_req_valid), .req_ready(nz_req_ready), .req_we(2'b00),
    .req_addr(8'h00), .req_din(4'h0), .rsp_valid(nz_rsp_valid), .rsp_data(nz_rsp_data),
    .init_done(nz_init_done), .csb0(nz_csb0), .web0(nz_web0), .addr0(nz_addr0), .din0(nz_din0),
    .dout0(nz_dout0));

  // Macro model: latch command on the rising edge, act on the falling edge.
  logic [1:0] mem [16];
  logic       m_csb = 1'b1, m_web = 1'b1;
  logic [3:0] m_addr = '0;
  logic [1:0] m_din = '0;
  initial dout0 = 2'b00;

  always @(posedge clk0) begin
    m_csb  <= csb0;
    m_web  <= web0;
    m_addr <= addr0;
    m_din  <= din0;
  end

  always @(negedge clk0) begin
    if (!m_csb) begin
      if (!m_web) mem[m_addr] <= m_din;
      else        dout0 <= mem[m_addr];
    end
  end

  task automatic tick();
    @(posedge clk0);
    #1;
  endtask

  task automatic drive(input int i, input logic v, input logic we, input logic [3:0] a, input logic [1:0] d);
    req_valid[i]      = v;
    req_we[i]         = we;
    req_addr[i*4 +: 4] = a;
    req_din[i*2 +: 2]  = d;
  endtask

  task automatic test_no_init();
    rst0 = 1'b1;
    nz_req_valid = 2'b01;
    tick();
    vectors++; if (nz_req_ready !== 2'b00) begin miscompares++; $display("FAIL nz_ready_in_reset got %b exp 00", nz_req_ready); end
    vectors++; if (nz_init_done !== 1'b0) begin miscompares++; $display("FAIL nz_init_done_in_reset got %b exp 0", nz_init_done); end
    rst0 = 1'b0;
    #1;
    vectors++; if (nz_req_ready !== 2'b01) begin miscompares++; $display("FAIL nz_ready_after_release got %b exp 01", nz_req_ready); end
    tick();
    nz_req_valid = 2'b00;
    vectors++; if (nz_init_done !== 1'b1) begin miscompares++; $display("FAIL nz_init_done_first_edge got %b exp 1", nz_init_done); end
    vectors++; if ({nz_csb0, nz_web0} !== 2'b01) begin miscompares++; $display("FAIL nz_read_issued csb/web got %b exp 01", {nz_csb0, nz_web0}); end
  endtask

  task automatic test_reset();
    rst0 = 1'b1;
    req_valid = '0;
    tick();
    vectors++; if ({csb0, web0} !== 2'b11) begin miscompares++; $display("FAIL reset csb/web got %b exp 11", {csb0, web0}); end
    vectors++; if ({addr0, din0} !== 6'h00) begin miscompares++; $display("FAIL reset addr/din got %h exp 00", {addr0, din0}); end
    vectors++; if ({req_ready, rsp_valid, rsp_data, init_done} !== 7'h00) begin miscompares++;
      $display("FAIL reset ready/rsp/done got %h exp 00", {req_ready, rsp_valid, rsp_data, init_done}); end
    drive(0, 1'b1, 1'b0, 4'd9, 2'b00);
    rst0 = 1'b0;
    #1;
    vectors++; if (req_ready !== 2'b00) begin miscompares++; $display("FAIL init_ready_pre got %b exp 00", req_ready); end
    for (int k = 1; k <= 16; k++) begin
      tick();
      vectors++; if ({csb0, web0, din0} !== 4'b0000 || addr0 !== 4'(k - 1)) begin miscompares++;
        $display("FAIL init_cycle%0d csb/web/din %b addr %0d exp 0000 addr %0d", k, {csb0, web0, din0}, addr0, k - 1); end
      vectors++; if (init_done !== (k == 16)) begin miscompares++; $display("FAIL init_done_cycle%0d got %b exp %b", k, init_done, k == 16); end
      vectors++; if (req_ready !== ((k == 16) ? 2'b01 : 2'b00)) begin miscompares++;
        $display("FAIL init_ready_cycle%0d got %b exp %b", k, req_ready, (k == 16) ? 2'b01 : 2'b00); end
    end
    tick();
    drive(0, 1'b0, 1'b0, 4'd0, 2'b00);
    vectors++; if ({csb0, web0, addr0} !== 6'b01_1001) begin miscompares++; $display("FAIL read9_cmd got %b exp 011001", {csb0, web0, addr0}); end
    tick();
    vectors++; if (rsp_valid !== 2'b00) begin miscompares++; $display("FAIL read9_early got %b exp 00", rsp_valid); end
    tick();
    vectors++; if (rsp_valid !== 2'b01 || rsp_data !== 2'b00) begin miscompares++;
      $display("FAIL read9_rsp valid %b data %b exp 01/00", rsp_valid, rsp_data); end
    tick();
    vectors++; if (csb0 !== 1'b1 || rsp_valid !== 2'b00) begin miscompares++; $display("FAIL idle csb %b rsp %b exp 1/00", csb0, rsp_valid); end
  endtask

  task automatic test_write_read();
    drive(0, 1'b1, 1'b1, 4'd3, 2'b10);
    tick();
    vectors++; if ({csb0, web0, addr0, din0} !== 8'b00_0011_10) begin miscompares++;
      $display("FAIL wr3_cmd got %b exp 00001110", {csb0, web0, addr0, din0}); end
    drive(0, 1'b1, 1'b0, 4'd3, 2'b00);
    tick();
    drive(0, 1'b0, 1'b0, 4'd0, 2'b00);
    vectors++; if ({csb0, web0, addr0} !== 6'b01_0011) begin miscompares++; $display("FAIL rd3_cmd got %b exp 010011", {csb0, web0, addr0}); end
    tick();
    vectors++; if (rsp_valid !== 2'b00) begin miscompares++; $display("FAIL rd3_early got %b exp 00", rsp_valid); end
    tick();
    vectors++; if (rsp_valid !== 2'b01 || rsp_data !== 2'b10) begin miscompares++;
      $display("FAIL rd3_rsp valid %b data %b exp 01/10", rsp_valid, rsp_data); end
    tick();
    vectors++; if (rsp_valid !== 2'b00 || rsp_data !== 2'b10) begin miscompares++;
      $display("FAIL rd3_hold valid %b data %b exp 00/10", rsp_valid, rsp_data); end
  endtask

  task automatic test_alternate();
    logic [1:0] exp_g [6];
    // pointer sits at 0 here, so requester 1 wins the first contested cycle
    drive(0, 1'b1, 1'b1, 4'd1, 2'b01);
    drive(1, 1'b1, 1'b1, 4'd2, 2'b11);
    #1;
    vectors++; if (req_ready !== 2'b10) begin miscompares++; $display("FAIL wr_arb_first got %b exp 10", req_ready); end
    tick();
    vectors++; if (req_ready !== 2'b01) begin miscompares++; $display("FAIL wr_arb_second got %b exp 01", req_ready); end
    tick();
    drive(0, 1'b1, 1'b0, 4'd1, 2'b00);
    drive(1, 1'b1, 1'b0, 4'd2, 2'b00);
    for (int j = 0; j < 8; j++) begin
      if (j == 6) req_valid = 2'b00;
      #1;
      if (j < 6) begin
        exp_g[j] = (j % 2 == 0) ? 2'b10 : 2'b01;
        vectors++; if (req_ready !== exp_g[j]) begin miscompares++; $display("FAIL alt_grant%0d got %b exp %b", j, req_ready, exp_g[j]); end
      end
      tick();
      if (j >= 2) begin
        vectors++; if (rsp_valid !== exp_g[j-2] || rsp_data !== ((exp_g[j-2] == 2'b10) ? 2'b11 : 2'b01)) begin miscompares++;
          $display("FAIL alt_rsp%0d valid %b data %b exp %b/%b", j - 2, rsp_valid, rsp_data, exp_g[j-2],
                   (exp_g[j-2] == 2'b10) ? 2'b11 : 2'b01); end
      end
    end
  endtask

  task automatic test_stream();
    logic [1:0] exp_mem [16];
    for (int a = 0; a < 16; a++) exp_mem[a] = 2'b00;
    exp_mem[1] = 2'b01;
    exp_mem[2] = 2'b11;
    exp_mem[3] = 2'b10;
    for (int j = 0; j < 18; j++) begin
      if (j < 16) drive(1, 1'b1, 1'b0, 4'(j), 2'b00);
      else        drive(1, 1'b0, 1'b0, 4'd0, 2'b00);
      #1;
      vectors++; if (req_ready !== ((j < 16) ? 2'b10 : 2'b00)) begin miscompares++;
        $display("FAIL stream_ready%0d got %b exp %b", j, req_ready, (j < 16) ? 2'b10 : 2'b00); end
      tick();
      if (j >= 2) begin
        vectors++; if (rsp_valid !== 2'b10 || rsp_data !== exp_mem[j-2]) begin miscompares++;
          $display("FAIL stream_rsp_addr%0d valid %b data %b exp 10/%b", j - 2, rsp_valid, rsp_data, exp_mem[j-2]); end
      end
    end
  endtask

  task automatic test_drop_valid();
    // pointer is at 1 after the stream: requester 0 must win and keep winning after an abandoned cycle
    drive(0, 1'b1, 1'b0, 4'd5, 2'b00);
    drive(1, 1'b1, 1'b0, 4'd6, 2'b00);
    #1;
    vectors++; if (req_ready !== 2'b01) begin miscompares++; $display("FAIL drop_first got %b exp 01", req_ready); end
    req_valid = 2'b00;
    tick();
    vectors++; if (csb0 !== 1'b1) begin miscompares++; $display("FAIL drop_no_cmd csb got %b exp 1", csb0); end
    req_valid = 2'b11;
    #1;
    vectors++; if (req_ready !== 2'b01) begin miscompares++; $display("FAIL drop_ptr_kept got %b exp 01", req_ready); end
    tick();
    req_valid = 2'b00;
    tick();
  endtask

  task automatic test_reset_inflight();
    int pulses;
    drive(0, 1'b1, 1'b0, 4'd1, 2'b00);
    tick();
    drive(0, 1'b1, 1'b0, 4'd2, 2'b00);
    tick();
    drive(0, 1'b0, 1'b0, 4'd0, 2'b00);
    rst0 = 1'b1;
    #1;
    vectors++; if ({csb0, web0, addr0} !== 6'b11_0000) begin miscompares++; $display("FAIL rst_async csb/web/addr got %b exp 110000", {csb0, web0, addr0}); end
    vectors++; if ({rsp_valid, init_done, req_ready} !== 5'b0) begin miscompares++;
      $display("FAIL rst_async rsp/done/ready got %b exp 00000", {rsp_valid, init_done, req_ready}); end
    tick();
    rst0 = 1'b0;
    pulses = 0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (rsp_valid !== 2'b00) pulses++;
      if (k <= 2) begin
        vectors++; if (csb0 !== 1'b0 || web0 !== 1'b0 || addr0 !== 4'(k - 1)) begin miscompares++;
          $display("FAIL reinit%0d csb/web %b addr %0d exp 00 addr %0d", k, {csb0, web0}, addr0, k - 1); end
      end
    end
    vectors++; if (pulses != 0) begin miscompares++; $display("FAIL rst_discard rsp pulses got %0d exp 0", pulses); end
    vectors++; if (init_done !== 1'b1) begin miscompares++; $display("FAIL reinit_done got %b exp 1", init_done); end
  endtask

  initial begin
    test_no_init();
    test_reset();
    test_write_read();
    test_alternate();
    test_stream();
    test_drop_valid();
    test_reset_inflight();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
